// File: rtl/mybus_arbiter.sv
// Two-requester Mybus arbiter: grants one whole transaction at a time, round-robin on ties,
// and steers acks/responses to the granted port only.
module mybus_arbiter #(
  parameter int unsigned BEATS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] p0_req,
  input  logic [12:0] p0_reqtag,
  input  logic        p0_reqcyc,
  output logic        p0_reqack,
  output logic        p0_respcyc,
  output logic [63:0] p0_resp,
  input  logic        p0_respack,
  input  logic [63:0] p1_req,
  input  logic [12:0] p1_reqtag,
  input  logic        p1_reqcyc,
  output logic        p1_reqack,
  output logic        p1_respcyc,
  output logic [63:0] p1_resp,
  input  logic        p1_respack,
  output logic [63:0] bus_req,
  output logic [12:0] bus_reqtag,
  output logic        bus_reqcyc,
  output logic        bus_bid,
  input  logic        bus_reqack,
  input  logic [63:0] bus_resp,
  input  logic        bus_respcyc,
  output logic        bus_respack
);

  localparam logic [7:0] BEATS_C     = BEATS[7:0];
  localparam logic [3:0] TYPE_MEMORY = 4'b0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e     state_q;
  logic       grant_q;
  logic       last_q;
  logic       dir_q;
  logic       short_q;
  logic       addr_done_q;
  logic [7:0] count_q;

  logic [63:0] sel_req_s;
  logic [12:0] sel_reqtag_s;
  logic        sel_reqcyc_s;
  logic        sel_respack_s;
  logic        in_req_s;
  logic        in_resp_s;
  logic        req_acc_s;
  logic        resp_acc_s;
  logic [7:0]  count_inc_s;
  logic [7:0]  target_s;
  logic        any_req_s;
  logic        win_s;
  logic        win_dir_s;
  logic [3:0]  win_type_s;

  assign sel_req_s     = grant_q ? p1_req     : p0_req;
  assign sel_reqtag_s  = grant_q ? p1_reqtag  : p0_reqtag;
  assign sel_reqcyc_s  = grant_q ? p1_reqcyc  : p0_reqcyc;
  assign sel_respack_s = grant_q ? p1_respack : p0_respack;

  assign in_req_s    = (state_q == REQ);
  assign in_resp_s   = (state_q == RESP);
  assign count_inc_s = count_q + 8'd1;
  assign target_s    = short_q ? 8'd1 : BEATS_C;

  // Bus side only carries the granted requester while in REQ; zeros otherwise
  assign bus_reqcyc  = in_req_s && sel_reqcyc_s;
  assign bus_req     = in_req_s ? sel_req_s    : 64'd0;
  assign bus_reqtag  = in_req_s ? sel_reqtag_s : 13'd0;
  assign bus_bid     = grant_q;
  assign bus_respack = in_resp_s && bus_respcyc && sel_respack_s;

  assign req_acc_s  = bus_reqcyc && bus_reqack;
  assign resp_acc_s = bus_respack;

  assign p0_reqack  = req_acc_s && !grant_q;
  assign p1_reqack  = req_acc_s && grant_q;
  assign p0_respcyc = in_resp_s && bus_respcyc && !grant_q;
  assign p1_respcyc = in_resp_s && bus_respcyc && grant_q;
  assign p0_resp    = bus_resp;
  assign p1_resp    = bus_resp;

  assign any_req_s  = p0_reqcyc || p1_reqcyc;
  assign win_dir_s  = win_s ? p1_reqtag[12]   : p0_reqtag[12];
  assign win_type_s = win_s ? p1_reqtag[11:8] : p0_reqtag[11:8];

  // Winner selection: a tie goes to the port not serviced last
  always_comb begin
    win_s = 1'b0;
    if (p0_reqcyc && p1_reqcyc) begin
      win_s = ~last_q;
    end else if (p1_reqcyc) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Transaction sequencer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      dir_q       <= 1'b0;
      short_q     <= 1'b0;
      addr_done_q <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req_s) begin
            grant_q     <= win_s;
            dir_q       <= win_dir_s;
            short_q     <= (win_type_s != TYPE_MEMORY);
            addr_done_q <= 1'b0;
            count_q     <= 8'd0;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (req_acc_s) begin
            if (dir_q) begin
              count_q <= 8'd0;
              state_q <= RESP;
            end else if (!addr_done_q) begin
              addr_done_q <= 1'b1;
            end else begin
              // Write data beats counted after the address beat
              count_q <= count_inc_s;
              if (count_inc_s == target_s) begin
                last_q  <= grant_q;
                state_q <= IDLE;
              end
            end
          end
        end
        RESP: begin
          if (resp_acc_s) begin
            count_q <= count_inc_s;
            if (count_inc_s == target_s) begin
              last_q  <= grant_q;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
